// File: rtl/fifo_pkg.sv
// Shared FIFO types: status flag bundle and depth helper used by FIFOs across the codebase.
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t FIFO_STATUS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1
  };

  function automatic int unsigned fifo_depth(input int unsigned awidth);
    return 32'(1) << awidth;
  endfunction

endpackage

// File: rtl/fwft_fifo_ctrl.sv
// FWFT FIFO control: accept logic, pointers, occupancy count, registered flags and sticky errors.
module fwft_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              write,
  input  logic              read,
  input  logic              flush,
  input  logic              err_clear,
  input  logic [AWIDTH:0]   prog_full_thresh,
  input  logic [AWIDTH:0]   prog_empty_thresh,
  output logic              wr_acc,
  output logic              rd_acc,
  output logic              bypass,
  output logic [AWIDTH-1:0] wr_ptr,
  output logic [AWIDTH-1:0] rd_ptr,
  output logic [AWIDTH:0]   data_count,
  output fifo_status_t      status,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = fifo_depth(AWIDTH);
  localparam int unsigned CW    = AWIDTH + 1;

  logic [CW-1:0]     count_nxt;
  logic [AWIDTH-1:0] wr_ptr_nxt;
  logic [AWIDTH-1:0] rd_ptr_nxt;
  fifo_status_t      status_nxt;
  logic              overflow_nxt;
  logic              underflow_nxt;

  // Next-state: flush discards the cycle's requests, so they are gated out of accept.
  always_comb begin
    wr_acc     = write && !status.full && !flush;
    rd_acc     = read && !status.empty && !flush;
    bypass     = wr_acc && ((data_count == '0) || (rd_acc && (data_count == CW'(1))));
    count_nxt  = data_count;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;

    if (flush) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (wr_acc && !rd_acc) begin
        count_nxt = data_count + CW'(1);
      end else if (rd_acc && !wr_acc) begin
        count_nxt = data_count - CW'(1);
      end
      if (wr_acc && !bypass) begin
        wr_ptr_nxt = wr_ptr + AWIDTH'(1);
      end
      // Memory holds words behind the head only when more than one is occupied.
      if (rd_acc && (data_count > CW'(1))) begin
        rd_ptr_nxt = rd_ptr + AWIDTH'(1);
      end
    end

    status_nxt.full         = (count_nxt == CW'(DEPTH));
    status_nxt.almost_full  = (prog_full_thresh != '0) && (count_nxt >= prog_full_thresh);
    status_nxt.empty        = (count_nxt == '0);
    status_nxt.almost_empty = (count_nxt <= prog_empty_thresh);

    overflow_nxt  = (write && status.full && !flush) || (overflow && !err_clear);
    underflow_nxt = (read && status.empty && !flush) || (underflow && !err_clear);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      data_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      status     <= FIFO_STATUS_RESET;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_count <= count_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      status     <= status_nxt;
      overflow   <= overflow_nxt;
      underflow  <= underflow_nxt;
    end
  end

endmodule

// File: rtl/fwft_fifo_prog.sv
// First-word-fall-through FIFO with programmable thresholds, flush and sticky errors.
module fwft_fifo_prog
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH = 2,
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              write,
  input  logic [DWIDTH-1:0] data_in,
  input  logic              read,
  output logic [DWIDTH-1:0] data_out,
  input  logic              flush,
  input  logic              err_clear,
  input  logic [AWIDTH:0]   prog_full_thresh,
  input  logic [AWIDTH:0]   prog_empty_thresh,
  output logic              full,
  output logic              almost_full,
  output logic              empty,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [AWIDTH:0]   data_count
);

  localparam int unsigned DEPTH = fifo_depth(AWIDTH);
  localparam int unsigned CW    = AWIDTH + 1;

  logic              wr_acc;
  logic              rd_acc;
  logic              bypass;
  logic [AWIDTH-1:0] wr_ptr;
  logic [AWIDTH-1:0] rd_ptr;
  fifo_status_t      status;
  logic [DWIDTH-1:0] mem [DEPTH];

  fwft_fifo_ctrl #(.AWIDTH(AWIDTH)) u_ctrl (
    .clk               (clk),
    .res               (res),
    .write             (write),
    .read              (read),
    .flush             (flush),
    .err_clear         (err_clear),
    .prog_full_thresh  (prog_full_thresh),
    .prog_empty_thresh (prog_empty_thresh),
    .wr_acc            (wr_acc),
    .rd_acc            (rd_acc),
    .bypass            (bypass),
    .wr_ptr            (wr_ptr),
    .rd_ptr            (rd_ptr),
    .data_count        (data_count),
    .status            (status),
    .overflow          (overflow),
    .underflow         (underflow)
  );

  assign full         = status.full;
  assign almost_full  = status.almost_full;
  assign empty        = status.empty;
  assign almost_empty = status.almost_empty;

  // Storage behind the head word; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !bypass) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Head register: bypass from the input or refill from memory on a pop.
  always_ff @(posedge clk) begin
    if (res) begin
      data_out <= '0;
    end else if (bypass) begin
      data_out <= data_in;
    end else if (rd_acc && (data_count > CW'(1))) begin
      data_out <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_fwft_fifo_prog.sv
// Scoreboard bench for fwft_fifo_prog: queue-based reference model, directed then random traffic.
module tb_fwft_fifo_prog;

  localparam int unsigned AW    = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          res, write, read, flush, err_clear;
  logic [DW-1:0] data_in, data_out;
  logic [AW:0]   prog_full_thresh, prog_empty_thresh, data_count;
  logic          full, almost_full, empty, almost_empty, overflow, underflow;

  always #5 clk = ~clk;

  fwft_fifo_prog #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk               (clk),
    .res               (res),
    .write             (write),
    .data_in           (data_in),
    .read              (read),
    .data_out          (data_out),
    .flush             (flush),
    .err_clear         (err_clear),
    .prog_full_thresh  (prog_full_thresh),
    .prog_empty_thresh (prog_empty_thresh),
    .full              (full),
    .almost_full       (almost_full),
    .empty             (empty),
    .almost_empty      (almost_empty),
    .overflow          (overflow),
    .underflow         (underflow),
    .data_count        (data_count)
  );

  typedef struct {
    int            cnt;
    bit            full, af, empty, ae, ovf, unf, dchk;
    logic [DW-1:0] dout;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;
  int            t_pft = 3, t_pet = 1;
  int            n_checks = 0, n_pass = 0;
  exp_t          me;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
  endtask

  // One clock: drive inputs, advance the reference model, queue the expected post-edge state.
  task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f,
                     input bit ec, input bit rs);
    exp_t          e;
    bit            was_full, was_empty;
    logic [DW-1:0] tmp;
    write = w; data_in = d; read = r; flush = f; err_clear = ec; res = rs;
    prog_full_thresh  = (AW+1)'(t_pft);
    prog_empty_thresh = (AW+1)'(t_pet);
    if (rs) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      e.dchk = 1'b1;
      e.dout = '0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      m_ovf = (w && was_full && !f) || (m_ovf && !ec);
      m_unf = (r && was_empty && !f) || (m_unf && !ec);
      if (f) mq.delete();
      else begin
        if (r && !was_empty) tmp = mq.pop_front();
        if (w && !was_full) mq.push_back(d);
      end
      e.dchk = (mq.size() > 0);
      e.dout = e.dchk ? mq[0] : '0;
    end
    e.cnt   = mq.size();
    e.full  = (e.cnt == DEPTH);
    e.af    = (t_pft != 0) && (e.cnt >= t_pft);
    e.empty = (e.cnt == 0);
    e.ae    = (e.cnt <= t_pet);
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d); cyc(1, d, 0, 0, 0, 0); endtask
  task automatic rd();                       cyc(0, 0, 1, 0, 0, 0); endtask
  task automatic idle();                     cyc(0, 0, 0, 0, 0, 0); endtask

  // Monitor: compares the DUT against the oldest expectation after each edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        check("data_count",   int'(data_count),   me.cnt);
        check("full",         int'(full),         int'(me.full));
        check("almost_full",  int'(almost_full),  int'(me.af));
        check("empty",        int'(empty),        int'(me.empty));
        check("almost_empty", int'(almost_empty), int'(me.ae));
        check("overflow",     int'(overflow),     int'(me.ovf));
        check("underflow",    int'(underflow),    int'(me.unf));
        if (me.dchk) check("data_out", int'(data_out), int'(me.dout));
      end
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    idle();
    // Single word round trip
    wr(8'hA5); rd(); idle();
    // Fill to full then drain in order
    for (int i = 1; i <= 4; i++) wr(8'(i));
    for (int i = 0; i < 4; i++) rd();
    // Write while full with a simultaneous pop, then clear the error
    for (int i = 1; i <= 4; i++) wr(8'(i));
    cyc(1, 8'h55, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    // Bypass at count 1, then underflow
    rd(); rd(); rd();
    wr(8'h10);
    cyc(1, 8'h20, 1, 0, 0, 0);
    rd(); rd(); idle();
    // Flush with a concurrent write keeps errors
    for (int i = 0; i < 3; i++) wr(8'(8'h30 + i));
    cyc(1, 8'hEE, 0, 1, 0, 0);
    wr(8'h77); idle(); rd();
    cyc(0, 0, 0, 0, 1, 0);
    // Pointer wrap with order preserved
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) wr(8'(8'h80 + 4*k + i));
      for (int i = 0; i < 4; i++) rd();
    end
    // Reset mid-stream
    wr(8'hC1); wr(8'hC2); cyc(1, 8'h01, 1, 0, 0, 0);
    cyc(1, 8'hC3, 1, 0, 0, 1);
    idle(); wr(8'hC4); rd();
    // Random traffic with changing thresholds
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        t_pft = int'($urandom_range(0, DEPTH));
        t_pet = int'($urandom_range(0, DEPTH));
      end
      cyc($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3, $urandom_range(0, 199) == 0);
    end
    idle();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
